mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Multi-cycle shift-and-add multiply sequencer for the CPU datapath.
//  - Returns the low WIDTH bits of src1_i*src2_i.
//  - The low word is identical for signed and unsigned operands.
//  - Reuses the 32-bit Adder, issuing one accumulate per clock, so no combinational multiplier is needed.
//  - Sits beside the ALU; the pipeline control stalls on busy_o and captures result_o on done_o.
// PARAMETERS
//  WIDTH       32  operand/result width; must equal the Adder width (32)
//  EARLY_EXIT  1   1: stop when remaining multiplier bits are all zero; 0: always WIDTH iterations
//  CNT_W       6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk_i     in   1      clock, rising edge
//  rst_i     in   1      asynchronous reset, active-low
//  start_i   in   1      request; accepted on a rising edge with start_i && ready_o && !flush_i
//  flush_i   in   1      synchronous abort; highest priority after reset
//  src1_i    in   WIDTH  multiplicand, sampled at accept
//  src2_i    in   WIDTH  multiplier, sampled at accept
//  ready_o   out  1      1 only in IDLE
//  busy_o    out  1      1 in RUN or DONE
//  done_o    out  1      1-cycle completion pulse
//  result_o  out  WIDTH  product low word; registered
// BEHAVIOUR
//  Reset (rst_i=0, async):
//   - state=IDLE, acc=0, mcand=0, mplier=0, cnt=0
//   - result_o=0, done_o=0, busy_o=0, ready_o=1
//  FSM states IDLE, RUN, DONE; all outputs are decoded from registered state.
//   - IDLE: ready_o=1. On accept: mcand<=src1_i, mplier<=src2_i, acc<=0, cnt<=0, ->RUN.
//   - RUN, per edge:
//     - if mplier[0]: acc<=Adder(acc,mcand), modulo 2**WIDTH, carry discarded
//     - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1
//     - exit to DONE when cnt==WIDTH-1, or when EARLY_EXIT && (mplier>>1)==0
//     - on exit, result_o<=value acc takes on this edge
//   - DONE: done_o=1 for exactly one cycle; ->IDLE on the next edge.
//   - ready_o=0 in DONE, so back-to-back requests are spaced by one idle edge.
//  Latency:
//   - k = iterations: WIDTH if EARLY_EXIT=0, else max(1, msb_index(src2_i)+1)
//   - src2_i==0 gives k=1
//   - done_o is high during the cycle following the k-th edge after the accepting edge
//  Other rules:
//   - start_i while busy_o=1 is ignored, not queued; operand changes while busy have no effect
//   - result_o holds its last value until the next completion; flush never modifies it
//   - flush_i in RUN or DONE: ->IDLE next edge, no done_o, acc discarded
//   - flush_i with start_i in IDLE: no accept
//   - async reset mid-operation: immediate return to reset values, no done_o
//   - WIDTH-bit wrap-around is intended behaviour and is never flagged
// STRUCTURE
//  Shared package/include:
//   - state encoding: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
//   - MUL_WIDTH=32
//  Sub-module: exactly one instance of the existing Adder (src1_i=acc, src2_i=mcand, sum_o=next acc).
//   - No other arithmetic operators on the accumulate path.
//  Counter, shift registers and FSM live in this module.
// TESTING
//  1. 3 x 5, EARLY_EXIT=1 -> k=3, done_o 3 edges after accept, result_o=32'd15, ready_o back 1 edge later
//  2. 0xFFFFFFFF x 0xFFFFFFFF -> k=32, result_o=32'h00000001; EARLY_EXIT=0: 7x2 also k=32, result 14
//  3. 7 x 0 -> k=1, result_o=0; then 0xFFFFFFFD(-3) x 4 -> k=3, result_o=32'hFFFFFFF4
//  4. 6x6 running, start_i with 9x9 mid-RUN -> ignored, result_o=36; 9x9 accepted only when ready_o=1
//  5. flush_i at 2nd RUN edge of 0x80000000x0x80000000 -> IDLE, no done_o, result_o keeps prior value
//  6. rst_i low mid-RUN (async, between edges) -> outputs at reset values before next edge; fresh 2x3 -> 6
//  Checks:
//   - scoreboard compares result_o with (a*b)&32'hFFFFFFFF
//   - assertions: done_o is a 1-cycle pulse; ready_o==!busy_o

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer.
package mul_seq_ctrl_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_seq_ctrl_adder.sv
// Datapath adder shared with the ALU; the multiply sequencer issues one accumulate per clock through it.
module mul_seq_ctrl_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] sum_o
);

    // Carry out is deliberately dropped: products wrap modulo 2**WIDTH.
    assign sum_o = src1_i + src2_i;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-and-add multiplier returning the low WIDTH bits of src1_i*src2_i.
// One accumulate per clock through the shared adder; optional early exit on an exhausted multiplier.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH      = MUL_WIDTH,
    parameter int EARLY_EXIT = 1,
    parameter int CNT_W      = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   sum;
    logic               last_iter;

    mul_seq_ctrl_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .src1_i (acc_q),
        .src2_i (mcand_q),
        .sum_o  (sum)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        last_iter = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    mcand_d  = src1_i;
                    mplier_d = src2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d     = mplier_q[0] ? sum : acc_q;
                    mcand_d   = mcand_q << 1;
                    mplier_d  = mplier_q >> 1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    // Early exit once no set multiplier bits remain to be consumed.
                    last_iter = (cnt_q == CNT_W'(WIDTH - 1)) ||
                                ((EARLY_EXIT != 0) && (mplier_d == '0));
                    if (last_iter) begin
                        state_d  = S_DONE;
                        result_d = acc_d;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign busy_o   = (state_q == S_RUN) || (state_q == S_DONE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: an early-exit instance (a) and a fixed-latency instance (b).
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, flush_a, start_b, flush_b;
    logic [31:0] src1_a, src2_a, src1_b, src2_b;
    logic        ready_a, busy_a, done_a, ready_b, busy_b, done_b;
    logic [31:0] result_a, result_b;
    logic        done_a_prev, done_b_prev;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.WIDTH(32), .EARLY_EXIT(1), .CNT_W(6)) u_dut_a (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .start_i  (start_a),
        .flush_i  (flush_a),
        .src1_i   (src1_a),
        .src2_i   (src2_a),
        .ready_o  (ready_a),
        .busy_o   (busy_a),
        .done_o   (done_a),
        .result_o (result_a)
    );

    mul_seq_ctrl #(.WIDTH(32), .EARLY_EXIT(0), .CNT_W(6)) u_dut_b (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .start_i  (start_b),
        .flush_i  (flush_b),
        .src1_i   (src1_b),
        .src2_i   (src2_b),
        .ready_o  (ready_b),
        .busy_o   (busy_b),
        .done_o   (done_b),
        .result_o (result_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol invariants sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("ready_a_eq_not_busy", {31'd0, ready_a}, {31'd0, !busy_a});
            chk("ready_b_eq_not_busy", {31'd0, ready_b}, {31'd0, !busy_b});
            chk("done_a_one_cycle", {31'd0, done_a && done_a_prev}, 32'd0);
            chk("done_b_one_cycle", {31'd0, done_b && done_b_prev}, 32'd0);
        end
        done_a_prev = done_a;
        done_b_prev = done_b;
    end

    task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input int exp_k, input logic [31:0] exp_r, input string tag);
        int n;
        bit seen;
        logic [31:0] res;
        logic [31:0] model;
        model = a * b;
        if (sel) begin
            src1_b = a; src2_b = b; start_b = 1'b1;
        end else begin
            src1_a = a; src2_a = b; start_a = 1'b1;
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "_busy_after_accept"}, {31'd0, sel ? busy_b : busy_a}, 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            seen = sel ? done_b : done_a;
        end
        res = sel ? result_b : result_a;
        chk({tag, "_latency"}, 32'(n), 32'(exp_k));
        chk({tag, "_result"}, res, exp_r);
        chk({tag, "_scoreboard"}, res, model);
        $display("op %s a=0x%08h b=0x%08h k=%0d result=0x%08h", tag, a, b, n, res);
        tick();
        chk({tag, "_ready_back"}, {31'd0, sel ? ready_b : ready_a}, 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start_a = 1'b0; flush_a = 1'b0; src1_a = '0; src2_a = '0;
        start_b = 1'b0; flush_b = 1'b0; src1_b = '0; src2_b = '0;
        done_a_prev = 1'b0; done_b_prev = 1'b0;
        #12;
        chk("reset_ready", {31'd0, ready_a}, 32'd1);
        chk("reset_busy", {31'd0, busy_a}, 32'd0);
        chk("reset_done", {31'd0, done_a}, 32'd0);
        chk("reset_result", result_a, 32'd0);
        chk("reset_b_result", result_b, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic early-exit multiply
        run_op(1'b0, 32'd3, 32'd5, 3, 32'd15, "t1_3x5");

        // 2: full-length operands and fixed-latency instance
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0001, "t2_ffxff");
        run_op(1'b1, 32'd7, 32'd2, 32, 32'd14, "t2_fixed_7x2");

        // 3: zero multiplier and signed operand
        run_op(1'b0, 32'd7, 32'd0, 1, 32'd0, "t3_7x0");
        run_op(1'b0, 32'hFFFF_FFFD, 32'd4, 3, 32'hFFFF_FFF4, "t3_m3x4");

        // 4: start while busy is ignored; 9x9 accepted once ready
        src1_a = 32'd6; src2_a = 32'd6; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        src1_a = 32'd9; src2_a = 32'd9; start_a = 1'b1;
        tick();
        tick();
        chk("t4_done_6x6", {31'd0, done_a}, 32'd1);
        chk("t4_result_36", result_a, 32'd36);
        $display("op t4_6x6 a=0x00000006 b=0x00000006 result=0x%08h", result_a);
        tick();
        chk("t4_not_queued_ready", {31'd0, ready_a}, 32'd1);
        chk("t4_result_holds", result_a, 32'd36);
        tick();
        start_a = 1'b0;
        chk("t4_9x9_accepted", {31'd0, busy_a}, 32'd1);
        n = 0;
        while (done_a !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t4_9x9_latency", 32'(n), 32'd4);
        chk("t4_9x9_result", result_a, 32'd81);
        $display("op t4_9x9 a=0x00000009 b=0x00000009 k=%0d result=0x%08h", n, result_a);
        tick();

        // 5: flush at the 2nd RUN edge
        src1_a = 32'h8000_0000; src2_a = 32'h8000_0000; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        chk("t5_flush_idle", {31'd0, ready_a}, 32'd1);
        chk("t5_flush_no_done", {31'd0, done_a}, 32'd0);
        chk("t5_flush_result_kept", result_a, 32'd81);
        n = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (done_a === 1'b1) n++;
        end
        chk("t5_no_late_done", 32'(n), 32'd0);
        $display("op t5_flush a=0x80000000 b=0x80000000 result=0x%08h", result_a);
        start_a = 1'b1; flush_a = 1'b1; src1_a = 32'd2; src2_a = 32'd2;
        tick();
        start_a = 1'b0; flush_a = 1'b0;
        chk("t5_flush_blocks_accept", {31'd0, ready_a}, 32'd1);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32, 32'd0, "t5_wrap");

        // 6: asynchronous reset between edges
        src1_a = 32'd6; src2_a = 32'd6; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_ready", {31'd0, ready_a}, 32'd1);
        chk("t6_async_busy", {31'd0, busy_a}, 32'd0);
        chk("t6_async_done", {31'd0, done_a}, 32'd0);
        chk("t6_async_result", result_a, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("t6_no_done_after_reset", {31'd0, done_a}, 32'd0);
        run_op(1'b0, 32'd2, 32'd3, 2, 32'd6, "t6_2x3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
